// File: rtl/mux_7seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: segment
// pattern type and the active-low gfedcba patterns for all sixteen codes.
package mux_7seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'b1000000;
    localparam seg7_t SEG_1     = 7'b1111001;
    localparam seg7_t SEG_2     = 7'b0100100;
    localparam seg7_t SEG_3     = 7'b0110000;
    localparam seg7_t SEG_4     = 7'b0011001;
    localparam seg7_t SEG_5     = 7'b0010010;
    localparam seg7_t SEG_6     = 7'b0000010;
    localparam seg7_t SEG_7     = 7'b1111000;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0011000;
    localparam seg7_t SEG_A     = 7'b0001000;
    localparam seg7_t SEG_B     = 7'b0000011;
    localparam seg7_t SEG_C     = 7'b1000110;
    localparam seg7_t SEG_D     = 7'b0100001;
    localparam seg7_t SEG_E     = 7'b0000110;
    localparam seg7_t SEG_F     = 7'b0001110;
    localparam seg7_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/mux_7seg_driver_seg7_encode.sv
// Combinational nibble-to-segment encoder. Codes 10..15 show letters only
// when hex_mode is set, otherwise they fall back to the "0" pattern.
module seg7_encode
    import mux_7seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output seg7_t      pattern
);

    // Look up the active-low pattern for the current nibble
    always_comb begin
        pattern = SEG_0;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = hex_mode ? SEG_A : SEG_0;
            4'hB: pattern = hex_mode ? SEG_B : SEG_0;
            4'hC: pattern = hex_mode ? SEG_C : SEG_0;
            4'hD: pattern = hex_mode ? SEG_D : SEG_0;
            4'hE: pattern = hex_mode ? SEG_E : SEG_0;
            4'hF: pattern = hex_mode ? SEG_F : SEG_0;
        endcase
    end

endmodule

// File: rtl/mux_7seg_driver.sv
// Time-multiplexed seven-segment display driver. A prescaler divides clk into
// digit slots; each slot starts with one all-off cycle to avoid ghosting, then
// drives the selected digit from the display register.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module mux_7seg_driver
    import mux_7seg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int HEX_MODE      = 0,
    parameter int AN_ACTIVE_LOW = 1,
    localparam int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx
);

    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [PRESC_W-1:0]    presc;
    logic [PRESC_W-1:0]    presc_next;
    logic                  slot_start;
    logic [IDX_W-1:0]      idx_next;
    logic [4*N_DIGITS-1:0] disp_val;
    logic [N_DIGITS-1:0]   disp_dp;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic [N_DIGITS-1:0]   an_onehot;
    seg7_t                 cur_pattern;
    seg7_t                 shown_pattern;

    // Prescaler and digit index advance; the output registers are loaded from
    // the next-state values so an/seg stay aligned with the slot they belong to
    always_comb begin
        slot_start = (presc == PRESC_W'(REFRESH_DIV - 1));
        presc_next = slot_start ? '0 : presc + PRESC_W'(1);
        idx_next   = digit_idx;
        if (slot_start) begin
            if (digit_idx == IDX_W'(N_DIGITS - 1))
                idx_next = '0;
            else
                idx_next = digit_idx + IDX_W'(1);
        end
    end

    // Select nibble, decimal point and enable bit of the digit about to be driven
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        an_onehot  = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx_next == IDX_W'(k)) begin
                cur_nibble   = disp_val[4*k +: 4];
                cur_dp       = disp_dp[k];
                an_onehot[k] = 1'b1;
            end
        end
    end

    seg7_encode u_encode (
        .nibble   (cur_nibble),
        .hex_mode (HEX_MODE != 0),
        .pattern  (cur_pattern)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] top_nz;

    // Locate the most significant nonzero digit; digits above it are blanked
    always_comb begin
        top_nz = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (disp_val[4*k +: 4] != 4'h0)
                top_nz = IDX_W'(k);
        end
        shown_pattern = (idx_next > top_nz) ? SEG_BLANK : cur_pattern;
    end
`else
    assign shown_pattern = cur_pattern;
`endif

    // Scan state, display register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            digit_idx <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
            an        <= AN_OFF;
        end else begin
            presc     <= presc_next;
            digit_idx <= idx_next;
            if (load) begin
                disp_val <= value;
                disp_dp  <= dp_in;
            end
            if (slot_start) begin
                seg <= SEG_BLANK;
                dp  <= 1'b1;
                an  <= AN_OFF;
            end else begin
                seg <= shown_pattern;
                dp  <= ~cur_dp;
                an  <= (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
            end
        end
    end

endmodule

// File: tb/tb_mux_7seg_driver.sv
// Self-checking bench for mux_7seg_driver: a 4-digit hex instance (active-low
// anodes) and a 1-digit decimal instance (active-high anode) share stimulus.
// The reference model derives slot position from the cycle count since reset.
module tb_mux_7seg_driver;

    localparam int DIV = 8;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    logic [6:0]  seg1;
    logic        dp1;
    logic [0:0]  an1;
    logic [0:0]  idx1;

    int checks;
    int errors;
    int cyc;
    logic [15:0] m_disp;
    logic [3:0]  m_dp;

    mux_7seg_driver #(
        .N_DIGITS      (4),
        .REFRESH_DIV   (DIV),
        .HEX_MODE      (1),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .digit_idx (digit_idx)
    );

    mux_7seg_driver #(
        .N_DIGITS      (1),
        .REFRESH_DIV   (DIV),
        .HEX_MODE      (0),
        .AN_ACTIVE_LOW (0)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value[3:0]),
        .dp_in     (dp_in[0:0]),
        .seg       (seg1),
        .dp        (dp1),
        .an        (an1),
        .digit_idx (idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] n, input bit hex);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0011000;
            4'hA: return hex ? 7'b0001000 : 7'b1000000;
            4'hB: return hex ? 7'b0000011 : 7'b1000000;
            4'hC: return hex ? 7'b1000110 : 7'b1000000;
            4'hD: return hex ? 7'b0100001 : 7'b1000000;
            4'hE: return hex ? 7'b0000110 : 7'b1000000;
            default: return hex ? 7'b0001110 : 7'b1000000;
        endcase
    endfunction

    // Digit pattern of the 4-digit display, honouring leading-zero blanking
    function automatic logic [6:0] model_seg4(input logic [15:0] d, input int dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && (d >> (4 * dig)) == 16'h0) return 7'b1111111;
`endif
        return enc(d[4*dig +: 4], 1'b1);
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    // Compare both instances against the model; od/odp = display content
    // held before the most recent edge
    task automatic check_outputs(input logic [15:0] od, input logic [3:0] odp);
        int pos;
        int dig;
        pos = cyc % DIV;
        dig = (cyc / DIV) % 4;
        if (pos == 0) begin
            check("seg_blank", {9'd0, seg}, 16'h7f);
            check("dp_blank",  {15'd0, dp}, 16'h1);
            check("an_off",    {12'd0, an}, 16'hf);
            check("seg1_blank", {9'd0, seg1}, 16'h7f);
            check("dp1_blank",  {15'd0, dp1}, 16'h1);
            check("an1_off",    {15'd0, an1}, 16'h0);
        end else begin
            check("seg", {9'd0, seg}, {9'd0, model_seg4(od, dig)});
            check("dp",  {15'd0, dp}, {15'd0, ~odp[dig]});
            check("an",  {12'd0, an}, {12'd0, ~(4'b0001 << dig)});
            check("seg1", {9'd0, seg1}, {9'd0, enc(od[3:0], 1'b0)});
            check("dp1",  {15'd0, dp1}, {15'd0, ~odp[0]});
            check("an1",  {15'd0, an1}, 16'h1);
        end
        check("digit_idx", {14'd0, digit_idx}, 16'(dig));
        check("idx1", {15'd0, idx1}, 16'h0);
    endtask

    task automatic tick();
        logic [15:0] od;
        logic [3:0]  odp;
        od  = m_disp;
        odp = m_dp;
        if (!rst && load) begin
            m_disp = value;
            m_dp   = dp_in;
        end
        @(posedge clk);
        if (!rst) cyc++;
        #1;
        check_outputs(od, odp);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        m_disp = '0;
        m_dp   = '0;
        rst    = 1'b1;
        load   = 1'b0;
        value  = '0;
        dp_in  = '0;

        // Reset state, load ignored while reset is held
        #2;
        check_outputs(16'h0, 4'h0);
        load  = 1'b1;
        value = 16'hFFFF;
        run(2);
        load  = 1'b0;
        rst   = 1'b0;

        // 1234 across all four slots
        value = 16'h1234;
        dp_in = 4'b0100;
        load  = 1'b1;
        tick();
        load = 1'b0;
        run(40);

        // Hex letters
        value = 16'hABCD;
        dp_in = 4'b0001;
        load  = 1'b1;
        tick();
        load = 1'b0;
        run(34);

        // Leading zeros
        value = 16'h0050;
        dp_in = 4'b1000;
        load  = 1'b1;
        tick();
        load = 1'b0;
        run(34);

        // Mid-slot load inside the digit-0 slot
        value = 16'h0000;
        load  = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cyc % (4 * DIV) == 3) break;
            tick();
        end
        value = 16'h0009;
        load  = 1'b1;
        tick();
        load = 1'b0;
        run(12);

        // Load on the slot-boundary edge
        for (int i = 0; i < DIV; i++) begin
            if (cyc % DIV == DIV - 1) break;
            tick();
        end
        value = 16'h8765;
        dp_in = 4'b0010;
        load  = 1'b1;
        tick();
        load = 1'b0;
        run(12);

        // Randomised loads
        for (int i = 0; i < 300; i++) begin
            value = 16'($urandom);
            dp_in = 4'($urandom);
            load  = ($urandom_range(0, 7) == 0);
            tick();
        end
        load = 1'b0;

        // Asynchronous reset mid-scan, then resume from slot 0
        for (int i = 0; i < DIV; i++) begin
            if (cyc % DIV == 4) break;
            tick();
        end
        #2;
        rst    = 1'b1;
        cyc    = 0;
        m_disp = '0;
        m_dp   = '0;
        #1;
        check_outputs(16'h0, 4'h0);
        load  = 1'b1;
        value = 16'h4321;
        run(2);
        load = 1'b0;
        rst  = 1'b0;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
